// File: rtl/ahblite_dma_master.sv
// Single-channel AHB-Lite master: copies word_count 32-bit words from src_addr to dst_addr, one read/write pair per word.
// Optional feature macro: DMA_FIXED_DST_EN adds the dst_fixed port (non-incrementing destination).
module ahblite_dma_master #(
  parameter int unsigned MAX_WORDS = 65535
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] word_count,
`ifdef DMA_FIXED_DST_EN
  input  logic        dst_fixed,
`endif
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_FINISH
  } state_t;

  localparam logic [1:0]  TRANS_IDLE   = 2'b00;
  localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
  localparam logic [15:0] MAX_CNT      = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic [31:0] haddr_q, haddr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_clamped;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        dst_hold;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};
  assign cnt_clamped = (32'(word_count) > MAX_WORDS) ? MAX_CNT : word_count;

`ifdef DMA_FIXED_DST_EN
  logic dst_hold_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                      dst_hold_q <= 1'b0;
    else if (state_q == S_IDLE && start) dst_hold_q <= dst_fixed;
  end
  assign dst_hold = dst_hold_q;
`else
  assign dst_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = {src_addr[31:2], 2'b00};
          dst_d   = {dst_addr[31:2], 2'b00};
          cnt_d   = cnt_clamped;
          err_d   = 1'b0;
          state_d = (cnt_clamped == 16'd0) ? S_FINISH : S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (HREADY) state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (HRESP) err_d = 1'b1;
        if (HREADY) begin
          if (HRESP) begin
            state_d = S_FINISH;
          end else begin
            data_d  = HRDATA;
            state_d = S_WR_ADDR;
          end
        end
      end
      S_WR_ADDR: if (HREADY) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (HRESP) err_d = 1'b1;
        if (HREADY) begin
          if (HRESP) begin
            state_d = S_FINISH;
          end else begin
            src_d   = src_q + 32'd4;
            dst_d   = dst_hold ? dst_q : dst_q + 32'd4;
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_q == 16'd1) ? S_FINISH : S_RD_ADDR;
          end
        end
      end
      // A zero-length request enters FINISH straight from IDLE and spends one
      // extra cycle here so done lands two cycles after start.
      S_FINISH: if (done_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    done_d   = (state_d == S_FINISH) && (state_q != S_IDLE);
    busy_d   = (state_d != S_IDLE) && !done_d;
    htrans_d = TRANS_IDLE;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    if (state_d == S_RD_ADDR) begin
      htrans_d = TRANS_NONSEQ;
      haddr_d  = src_d;
      hwrite_d = 1'b0;
    end else if (state_d == S_WR_ADDR) begin
      htrans_d = TRANS_NONSEQ;
      haddr_d  = dst_d;
      hwrite_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      cnt_q    <= 16'd0;
      data_q   <= 32'd0;
      haddr_q  <= 32'd0;
      htrans_q <= TRANS_IDLE;
      hwrite_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = data_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_dma_master.sv
// Bench for ahblite_dma_master: AHB slave model plus a scoreboard of expected bus accesses and done events.
module tb_ahblite_dma_master;

  logic        HCLK, HRESETn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
`ifdef DMA_FIXED_DST_EN
  logic        dst_fixed;
`endif
  logic        busy, done, error;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;

  ahblite_dma_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
`ifdef DMA_FIXED_DST_EN
    .dst_fixed(dst_fixed),
`endif
    .busy(busy), .done(done), .error(error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct packed { logic [31:0] addr; logic wr; logic [31:0] data; } acc_t;
  typedef struct packed { int cyc; logic err; } done_t;

  acc_t        exp_acc[$];
  done_t       exp_done[$];
  logic [31:0] mem [logic [31:0]];
  int checks = 0, errors = 0, cyc = 0;
  int waits = 0, err_rd = -1, rd_count = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model and access monitor: decides HREADY/HRESP mid-cycle and pops
  // the expected access each time an address phase is accepted.
  initial begin
    bit dp_act, dp_wr, dp_err, dp_first;
    logic [31:0] dp_addr, dp_haddr, dp_wdat, dp_exp;
    int dp_wait, dp_ecnt;
    acc_t e;
    dp_act = 0; dp_wr = 0; dp_err = 0; dp_first = 0;
    dp_addr = 0; dp_haddr = 0; dp_wdat = 0; dp_exp = 0; dp_wait = 0; dp_ecnt = 0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_act = 0; HREADY = 1'b1; HRESP = 1'b0;
        continue;
      end
      if (dp_act) begin
        chk("haddr_hold", HADDR, dp_haddr);
        if (dp_wr) begin
          if (dp_first) dp_wdat = HWDATA;
          else chk("hwdata_hold", HWDATA, dp_wdat);
        end
        dp_first = 0;
        if (dp_err) begin
          if (dp_ecnt == 0) begin HREADY = 1'b0; HRESP = 1'b1; dp_ecnt = 1; end
          else begin HREADY = 1'b1; HRESP = 1'b1; dp_act = 0; end
        end else if (dp_wait > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
          if (dp_wr) begin
            mem[dp_addr] = HWDATA;
            chk("wdata", HWDATA, dp_exp);
          end else begin
            HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : 32'hDEAD_BEEF;
          end
          dp_act = 0;
        end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
      end
      if (HREADY && HTRANS == 2'b10) begin
        if (exp_acc.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_nonseq: got addr %h write %0d, expected no transfer", HADDR, HWRITE);
          dp_exp = 32'd0;
        end else begin
          e = exp_acc.pop_front();
          chk("haddr", HADDR, e.addr);
          chk("hwrite", 32'(HWRITE), 32'(e.wr));
          dp_exp = e.data;
        end
        dp_act = 1; dp_wr = HWRITE; dp_addr = HADDR; dp_haddr = HADDR;
        dp_wait = waits; dp_first = 1; dp_ecnt = 0;
        dp_err = !HWRITE && (rd_count == err_rd);
        if (!HWRITE) rd_count++;
      end
    end
  end

  // Done monitor
  initial begin
    done_t dn;
    forever begin
      @(negedge HCLK);
      if (HRESETn && done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          dn = exp_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(dn.cyc));
          chk("error_at_done", 32'(error), 32'(dn.err));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Reference model: expected access list and done latency from the copy rules.
  task automatic run(input logic [31:0] src, input logic [31:0] dst, input int n, input int w,
                     input int err_at, input bit fixed, input int poke, input bit preset);
    logic [31:0] a, d;
    acc_t  e;
    done_t dn;
    int    p, lat, t;
    bit    aborted;
    @(negedge HCLK);
    waits = w; err_rd = err_at; rd_count = 0;
    aborted = (err_at >= 0) && (err_at < n);
    for (int i = 0; i < n; i++) begin
      a = src + 32'(4 * i);
      d = preset ? 32'(17 * (i + 1)) : $urandom;
      mem[a] = d;
      e.addr = a; e.wr = 1'b0; e.data = 32'd0;
      exp_acc.push_back(e);
      if (i == err_at) break;
      e.addr = fixed ? dst : dst + 32'(4 * i); e.wr = 1'b1; e.data = d;
      exp_acc.push_back(e);
    end
    p = 4 + 2 * w;
    if (n == 0)       lat = 2;
    else if (aborted) lat = err_at * p + 4;
    else              lat = n * p + 1;
    dn.cyc = cyc + lat; dn.err = aborted;
    exp_done.push_back(dn);
    start = 1'b1;
    src_addr = src | 32'($urandom_range(0, 3));
    dst_addr = dst | 32'($urandom_range(0, 3));
    word_count = 16'(n);
`ifdef DMA_FIXED_DST_EN
    dst_fixed = fixed;
`endif
    @(negedge HCLK);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("error_cleared", 32'(error), 32'd0);
    t = 0;
    while (exp_done.size() != 0 && t < 1000) begin
      if (poke > 0 && t == poke) begin
        start = 1'b1; src_addr = 32'h9999_0000; dst_addr = 32'h9999_1000; word_count = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge HCLK);
      t++;
    end
    start = 1'b0;
    if (exp_done.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
      exp_done.delete();
    end
    chk("accesses_left", 32'(exp_acc.size()), 32'd0);
    exp_acc.delete();
  endtask

  initial begin
    acc_t e;
    int t;
    HRESETn = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; word_count = 0;
`ifdef DMA_FIXED_DST_EN
    dst_fixed = 1'b0;
`endif
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("hsize", 32'(HSIZE), 32'd2);
    chk("hburst", 32'(HBURST), 32'd0);
    chk("hprot", 32'(HPROT), 32'd3);
    chk("hmastlock", 32'(HMASTLOCK), 32'd0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    run(32'h0000_0100, 32'h2000_0000, 4, 0, -1, 0, 0, 1);  // basic 4-word copy
    run(32'h0000_0300, 32'h2000_0100, 2, 2, -1, 0, 0, 0);  // two wait states per data phase
    run(32'h0000_0400, 32'h2000_0200, 3, 0,  1, 0, 0, 0);  // ERROR on second read
    run(32'h0000_0500, 32'h2000_0300, 0, 0, -1, 0, 0, 0);  // zero count
    run(32'h0000_0600, 32'h2000_0400, 3, 1, -1, 0, 5, 0);  // start while busy
`ifdef DMA_FIXED_DST_EN
    run(32'h0000_0700, 32'h4000_0000, 3, 0, -1, 1, 0, 0);  // fixed destination
`endif
    run(32'hFFFF_FFFC, 32'h2000_0500, 2, 0, -1, 0, 0, 0);  // source address wrap
    for (int k = 0; k < 12; k++) begin
      int n, w, ea;
      n  = $urandom_range(1, 5);
      w  = $urandom_range(0, 2);
      ea = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run(32'h0000_1000 + 32'($urandom_range(0, 63)) * 64,
          32'h2000_1000 + 32'($urandom_range(0, 63)) * 64, n, w, ea, 0, 0, 0);
    end

    // Reset asserted while the first write address phase is on the bus
    @(negedge HCLK);
    waits = 0; err_rd = -1; rd_count = 0;
    mem[32'h0000_0800] = 32'hA5A5_0001;
    e.addr = 32'h0000_0800; e.wr = 1'b0; e.data = 32'd0; exp_acc.push_back(e);
    e.addr = 32'h2000_0600; e.wr = 1'b1; e.data = 32'hA5A5_0001; exp_acc.push_back(e);
    start = 1'b1; src_addr = 32'h0000_0800; dst_addr = 32'h2000_0600; word_count = 16'd3;
    @(negedge HCLK);
    start = 1'b0;
    t = 0;
    while (!(HTRANS == 2'b10 && HWRITE) && t < 50) begin
      @(negedge HCLK);
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL wr_addr_timeout: got no write address phase, expected one");
    end
    HRESETn = 1'b0;
    #1;
    chk("midrst_htrans", 32'(HTRANS), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_haddr", HADDR, 32'd0);
    chk("midrst_hwrite", 32'(HWRITE), 32'd0);
    exp_acc.delete();
    exp_done.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (30) @(negedge HCLK);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run(32'h0000_0900, 32'h2000_0700, 2, 0, -1, 0, 0, 0);  // recovery after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
